// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RISC-V M-extension multiply/divide unit for the EX
//            stage. Radix-2 shift-add multiply and restoring division on
//            operand magnitudes, followed by a sign fix-up cycle. Holds the
//            front of the pipeline via a combinational stall while it works.
// Ports    : clk, reset (async, active-high)
//            start, op[2:0] (funct3), rs1_val, rs2_val, rd, flush   -> inputs
//            stall (comb), done (1-cycle pulse), result, result_rd  -> outputs
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [4:0]      rd,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      result_rd
);

    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [CW-1:0]   c_cnt_last = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] c_min      = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [XLEN-1:0]   r_a;        // multiplicand / dividend magnitude
    logic [XLEN-1:0]   r_b;        // multiplier / divisor magnitude
    logic [2*XLEN-1:0] r_acc;      // product, or {remainder, quotient}
    logic              r_neg_p;    // product / quotient sign
    logic              r_neg_r;    // remainder sign
    logic [XLEN-1:0]   r_result;
    logic [4:0]        r_result_rd;

    // ---------------- operand decode at acceptance ----------------
    logic            w_accept;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;

    assign w_accept   = (r_state == c_st_idle) & start & ~flush;
    // MUL only needs the low half, which is identical for signed and unsigned.
    assign w_a_signed = (op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110);
    assign w_b_signed = (op == 3'b001) | (op == 3'b100) | (op == 3'b110);
    assign w_sign_a   = w_a_signed & rs1_val[XLEN-1];
    assign w_sign_b   = w_b_signed & rs2_val[XLEN-1];
    assign w_mag_a    = w_sign_a ? -rs1_val : rs1_val;
    assign w_mag_b    = w_sign_b ? -rs2_val : rs2_val;
    assign w_b_zero   = (rs2_val == '0);
    assign w_ovf      = op[2] & ~op[0] & (rs1_val == c_min) & (rs2_val == '1);
    assign w_special  = op[2] & (w_b_zero | w_ovf);

    always_comb begin
        w_special_val = '1;
        if (w_b_zero) begin
            w_special_val = op[1] ? rs1_val : '1;
        end else begin
            w_special_val = op[1] ? '0 : rs1_val;
        end
    end

    // ---------------- per-iteration datapath ----------------
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_div_diff;
    logic              w_div_ge;
    logic [2*XLEN-1:0] w_mul_next;
    logic [2*XLEN-1:0] w_div_next;

    // Shift-add: add the multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring divide: bring in the next dividend bit and subtract the
    // divisor; a non-negative difference becomes the new partial remainder.
    assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_a[XLEN-1]};
    assign w_div_diff = w_rem_sh - {1'b0, r_b};
    assign w_div_ge   = ~w_div_diff[XLEN];
    assign w_div_next = {(w_div_ge ? w_div_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0]),
                         r_acc[XLEN-2:0], w_div_ge};

    // ---------------- sign fix-up and output select ----------------
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix;
    logic [XLEN-1:0]   w_rem_fix;
    logic [XLEN-1:0]   w_fix_val;

    assign w_prod_fix = r_neg_p ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg_p ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem_fix  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix_val = w_rem_fix;
        case (r_op)
            3'b000:                 w_fix_val = w_prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_val = w_quo_fix;
            default:                w_fix_val = w_rem_fix;
        endcase
    end

    // ---------------- state and datapath registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_neg_p     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_result    <= '0;
            r_result_rd <= '0;
        end else if (flush) begin
            // Abort wherever we are; the last committed result is kept.
            r_state <= c_st_idle;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_op    <= op;
                        r_rd    <= rd;
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_neg_p <= w_sign_a ^ w_sign_b;
                        r_neg_r <= w_sign_a;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        if (w_special) begin
                            r_result    <= w_special_val;
                            r_result_rd <= rd;
                            r_state     <= c_st_done;
                        end else begin
                            r_state <= c_st_calc;
                        end
                    end
                end
                c_st_calc: begin
                    if (r_op[2]) begin
                        r_acc <= w_div_next;
                        r_a   <= r_a << 1;
                    end else begin
                        r_acc <= w_mul_next;
                        r_b   <= r_b >> 1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_cnt_last) begin
                        r_state <= c_st_fix;
                    end
                end
                c_st_fix: begin
                    r_result    <= w_fix_val;
                    r_result_rd <= r_rd;
                    r_state     <= c_st_done;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign stall     = ~flush & (((r_state == c_st_idle) & start) |
                                 (r_state == c_st_calc) | (r_state == c_st_fix));
    assign done      = (r_state == c_st_done);
    assign result    = r_result;
    assign result_rd = r_result_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Self-checking bench for ex_muldiv_unit (XLEN = 64). A cycle-level
//            reference model derived from the M-extension arithmetic rules is
//            compared against the DUT every cycle; directed operations also
//            carry hand-computed literal results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam int          LAT = 65;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [63:0] rs1_val = 64'd0;
    logic [63:0] rs2_val = 64'd0;
    logic [4:0]  rd = 5'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        done;
    logic [63:0] result;
    logic [4:0]  result_rd;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .rd        (rd),
        .flush     (flush),
        .stall     (stall),
        .done      (done),
        .result    (result),
        .result_rd (result_rd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference arithmetic ----------------
    function automatic logic [63:0] ref_result(input logic [2:0] f, input logic [63:0] a,
                                               input logic [63:0] b);
        logic [127:0]       p;
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (f)
            3'd0: begin p = {64'd0, a} * {64'd0, b};               r = p[63:0];   end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b};   r = p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};         r = p[127:64]; end
            3'd3: begin p = {64'd0, a} * {64'd0, b};               r = p[127:64]; end
            3'd4: begin
                if (b == 64'd0)                          r = '1;
                else if (a == MIN && b == 64'hFFFF_FFFF_FFFF_FFFF) r = a;
                else                                     r = sa / sb;
            end
            3'd5: r = (b == 64'd0) ? '1 : a / b;
            3'd6: begin
                if (b == 64'd0)                          r = a;
                else if (a == MIN && b == 64'hFFFF_FFFF_FFFF_FFFF) r = 64'd0;
                else                                     r = sa % sb;
            end
            default: r = (b == 64'd0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [63:0] a,
                                      input logic [63:0] b);
        return f[2] && ((b == 64'd0) ||
                        (!f[0] && a == MIN && b == 64'hFFFF_FFFF_FFFF_FFFF));
    endfunction

    // ---------------- cycle-level model ----------------
    // k counts rising edges since reset. An op accepted at edge m_acc commits
    // its result at edge m_acc+m_lat, is done during the following cycle and
    // leaves the unit idle one edge later.
    int          k = 0;
    bit          m_pend = 1'b0;
    int          m_acc = 0;
    int          m_lat = 0;
    logic [63:0] m_pres = '0;
    logic [4:0]  m_prd = '0;
    logic [63:0] m_result = '0;
    logic [4:0]  m_rd = '0;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                k        = 0;
                m_pend   = 1'b0;
                m_result = '0;
                m_rd     = '0;
            end else begin
                if (flush) begin
                    m_pend = 1'b0;
                end else if ((!m_pend || k > m_acc + m_lat) && start) begin
                    m_pend = 1'b1;
                    m_acc  = k + 1;
                    m_lat  = is_special(op, rs1_val, rs2_val) ? 0 : LAT;
                    m_pres = ref_result(op, rs1_val, rs2_val);
                    m_prd  = rd;
                end
                k = k + 1;
                if (m_pend && k == m_acc + m_lat) begin
                    m_result = m_pres;
                    m_rd     = m_prd;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        bit e_done;
        bit e_busy;
        bit e_idle;
        bit e_stall;
        forever begin
            @(negedge clk);
            e_done  = m_pend && (k == m_acc + m_lat);
            e_busy  = m_pend && (k <  m_acc + m_lat);
            e_idle  = !m_pend || (k > m_acc + m_lat);
            e_stall = !flush && ((e_idle && start) || e_busy);
            chk("cyc_done",      64'(done),      64'(e_done));
            chk("cyc_stall",     64'(stall),     64'(e_stall));
            chk("cyc_result",    result,         m_result);
            chk("cyc_result_rd", 64'(result_rd), 64'(m_rd));
        end
    end

    // ---------------- directed operation ----------------
    // Called in an idle cycle just after a rising edge.
    task automatic do_op(input string name, input logic [2:0] f, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] r,
                         input logic [63:0] lit, input int lat);
        int n;
        int st;
        bit got;
        op      = f;
        rs1_val = a;
        rs2_val = b;
        rd      = r;
        start   = 1'b1;
        st      = 0;
        n       = 0;
        got     = 1'b0;
        @(negedge clk);
        if (stall) st++;
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 3'($urandom_range(0, 7));
        rs1_val = {$urandom, $urandom};
        rs2_val = {$urandom, $urandom};
        rd      = 5'($urandom_range(0, 31));
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (stall) st++;
        end
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout actual=no_done required=done", name);
        end
        chk({name, "_latency"}, 64'(n),  64'(lat + 1));
        chk({name, "_stalls"},  64'(st), 64'(lat + 1));
        chk({name, "_result"},  result,  lit);
        chk({name, "_rd"},      64'(result_rd), 64'(r));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int saw;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_rd",     64'(result_rd), 64'd0);
        chk("reset_done",   64'(done), 64'd0);
        chk("reset_stall",  64'(stall), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_op("mul",    3'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,  64'hFFFF_FFFF_FFFF_FFEB, LAT);
        do_op("mulhu",  3'd3, '1, '1, 5'd6,  64'hFFFF_FFFF_FFFF_FFFE, LAT);
        do_op("mulh",   3'd1, '1, '1, 5'd7,  64'd0, LAT);
        do_op("mulhsu", 3'd2, '1, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, LAT);
        do_op("div",    3'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9,  64'hFFFF_FFFF_FFFF_FFFD, LAT);
        do_op("rem",    3'd6, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, LAT);
        do_op("divu",   3'd5, 64'd100, 64'd7, 5'd11, 64'd14, LAT);
        do_op("remu",   3'd7, 64'd100, 64'd7, 5'd12, 64'd2,  LAT);
        do_op("divu0",  3'd5, 64'd55, 64'd0, 5'd13, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        do_op("rem0",   3'd6, 64'h1234, 64'd0, 5'd14, 64'h1234, 0);
        do_op("divovf", 3'd4, MIN, '1, 5'd15, MIN, 0);
        do_op("removf", 3'd6, MIN, '1, 5'd16, 64'd0, 0);
        do_op("remu_big", 3'd7, 64'h0123_4567_89AB_CDEF, 64'h10, 5'd17, 64'hF, LAT);

        // Flush while CALC is on iteration 20.
        op      = 3'd0;
        rs1_val = 64'd9;
        rs2_val = 64'd11;
        rd      = 5'd20;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        chk("flush_stall", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        saw   = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) saw++;
        end
        chk("flush_no_done",   64'(saw), 64'd0);
        chk("flush_keep_res",  result, 64'hF);
        chk("flush_keep_rd",   64'(result_rd), 64'd17);
        @(posedge clk);
        #1;
        do_op("mul_after_flush", 3'd0, 64'd3, 64'd5, 5'd21, 64'd15, LAT);

        // Asynchronous reset in the middle of CALC.
        op      = 3'd0;
        rs1_val = 64'd12345;
        rs2_val = 64'd678;
        rd      = 5'd22;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_result", result, 64'd0);
        chk("async_rst_rd",     64'(result_rd), 64'd0);
        chk("async_rst_done",   64'(done), 64'd0);
        chk("async_rst_stall",  64'(stall), 64'd0);
        reset = 1'b0;
        saw   = 0;
        repeat (80) begin
            @(negedge clk);
            if (done) saw++;
        end
        chk("async_rst_no_done", 64'(saw), 64'd0);
        @(posedge clk);
        #1;
        do_op("mul_after_reset", 3'd0, 64'd6, 64'd7, 5'd23, 64'd42, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
